// File: rtl/mult_div_unit_if.sv
// Start/Busy/Done handshake and HI/LO result bus between the control path and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       MDOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, MDOperation, A, B,
    input  Busy, Done, DivByZero, HI, LO
  );

  modport slave (
    input  Start, MDOperation, A, B,
    output Busy, Done, DivByZero, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: radix-2 shift-add multiply and
// restoring divide on magnitudes, one bit per clock, sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md
);

  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic               r_dbz_pend;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH:0]     r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi_out;
  logic [WIDTH-1:0]   r_lo_out;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH:0]     w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  logic [PROD_W-1:0]  w_prod;
  logic [PROD_W-1:0]  w_prod_fix;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // Operand magnitudes; MDOperation[0] set means unsigned
  assign w_a_neg = ~md.MDOperation[0] & md.A[WIDTH-1];
  assign w_b_neg = ~md.MDOperation[0] & md.B[WIDTH-1];
  assign w_a_mag = w_a_neg ? WIDTH'(-md.A) : md.A;
  assign w_b_mag = w_b_neg ? WIDTH'(-md.B) : md.B;

  // One iteration: r_hi carries the partial product / partial remainder
  always_comb begin
    w_add     = r_lo[0] ? {1'b0, r_opnd} : '0;
    w_mul_sum = r_hi + w_add;
    w_shift   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_opnd});
    w_diff    = w_shift - {1'b0, r_opnd};
    w_hi_nxt  = {1'b0, w_mul_sum[WIDTH:1]};
    w_lo_nxt  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      w_hi_nxt = w_ge ? w_diff : w_shift;
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    w_prod     = {r_hi[WIDTH-1:0], r_lo};
    w_prod_fix = r_neg_lo ? PROD_W'(-w_prod) : w_prod;
    w_rem_mag  = r_hi[WIDTH-1:0];
    w_quo      = r_neg_lo ? WIDTH'(-r_lo) : r_lo;
    w_rem      = r_neg_hi ? WIDTH'(-w_rem_mag) : w_rem_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_a_raw    <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi_out   <= '0;
      r_lo_out   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (md.Start) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_is_div   <= md.MDOperation[1];
            r_a_raw    <= md.A;
            r_dbz_pend <= md.MDOperation[1] & (md.B == '0);
            r_neg_lo   <= w_a_neg ^ w_b_neg;
            r_neg_hi   <= w_a_neg;
            r_hi       <= '0;
            // Divide shifts the dividend out of LO; multiply shifts the multiplier
            if (md.MDOperation[1]) begin
              r_opnd <= w_b_mag;
              r_lo   <= w_a_mag;
            end else begin
              r_opnd <= w_a_mag;
              r_lo   <= w_b_mag;
            end
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dbz   <= r_dbz_pend;
          if (!r_is_div) begin
            {r_hi_out, r_lo_out} <= w_prod_fix;
          end else if (r_dbz_pend) begin
            r_hi_out <= r_a_raw;
            r_lo_out <= '1;
          end else begin
            r_hi_out <= w_rem;
            r_lo_out <= w_quo;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md.Busy      = r_busy;
  assign md.Done      = r_done;
  assign md.DivByZero = r_dbz;
  assign md.HI        = r_hi_out;
  assign md.LO        = r_lo_out;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: results, latency, back-to-back ops,
// ignored Start while busy, and asynchronous reset of an in-flight operation.
module tb_mult_div_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NVEC  = 15;
  localparam int          LAT   = 33;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  vec_t vecs [NVEC];

  mult_div_unit_if #(.WIDTH(WIDTH)) md_if ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op now (called just after a rising edge) and count edges until Done
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    md_if.MDOperation = op;
    md_if.A           = a;
    md_if.B           = b;
    md_if.Start       = 1'b1;
    @(posedge clk);
    #1;
    md_if.Start       = 1'b0;
    md_if.A           = $urandom;
    md_if.B           = $urandom;
    md_if.MDOperation = 2'($urandom);
    check("busy_after_start", 64'(md_if.Busy), 64'd1);
    lat = 0;
    while (!md_if.Done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int cyc;
    int dones;

    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{OP_MULT,  32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0};
    vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{OP_MULTU, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
    vecs[11] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[12] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
    vecs[13] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[14] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

    md_if.Start       = 1'b0;
    md_if.MDOperation = 2'b00;
    md_if.A           = '0;
    md_if.B           = '0;
    reset             = 1'b1;
    #2 reset = 1'b0;
    #2;
    check("reset_busy", 64'(md_if.Busy), 64'd0);
    check("reset_done", 64'(md_if.Done), 64'd0);
    check("reset_dbz",  64'(md_if.DivByZero), 64'd0);
    check("reset_hi",   64'(md_if.HI), 64'd0);
    check("reset_lo",   64'(md_if.LO), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Each op starts in the Done cycle of the previous one
    for (int i = 0; i < int'(NVEC); i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("v%0d_busy_at_done", i), 64'(md_if.Busy), 64'd0);
      check($sformatf("v%0d_hi", i), 64'(md_if.HI), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(md_if.LO), 64'(vecs[i].lo));
      check($sformatf("v%0d_dbz", i), 64'(md_if.DivByZero), 64'(vecs[i].dbz));
    end

    // Done is a single pulse and results hold afterwards
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(md_if.Done), 64'd0);
    check("hold_hi", 64'(md_if.HI), 64'h1);
    check("hold_lo", 64'(md_if.LO), 64'h0);

    // Start pulse while busy must be ignored
    md_if.MDOperation = OP_MULT;
    md_if.A = 32'd6;
    md_if.B = 32'd7;
    md_if.Start = 1'b1;
    @(posedge clk);
    #1 md_if.Start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
    end
    md_if.MDOperation = OP_DIVU;
    md_if.A = 32'd3;
    md_if.B = 32'd9;
    md_if.Start = 1'b1;
    @(posedge clk);
    #1 md_if.Start = 1'b0;
    cyc = 5;
    while (!md_if.Done && cyc < 45) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("ign_latency", 64'(cyc), 64'(LAT));
    check("ign_lo", 64'(md_if.LO), 64'h2A);
    check("ign_hi", 64'(md_if.HI), 64'h0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (md_if.Done) dones++;
    end
    check("ign_no_second_done", 64'(dones), 64'd0);
    check("ign_idle_busy", 64'(md_if.Busy), 64'd0);

    // Asynchronous reset mid-operation discards it
    md_if.MDOperation = OP_MULT;
    md_if.A = 32'd6;
    md_if.B = 32'd7;
    md_if.Start = 1'b1;
    @(posedge clk);
    #1 md_if.Start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
    end
    check("rst_busy_before", 64'(md_if.Busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 64'(md_if.Busy), 64'd0);
    check("rst_done", 64'(md_if.Done), 64'd0);
    check("rst_hi",   64'(md_if.HI), 64'd0);
    check("rst_lo",   64'(md_if.LO), 64'd0);
    check("rst_dbz",  64'(md_if.DivByZero), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      #1;
      if (md_if.Done || md_if.Busy) dones++;
    end
    check("rst_no_done", 64'(dones), 64'd0);
    check("rst_lo_after", 64'(md_if.LO), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
